mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequential load/store controller that sits directly upstream of the data memory block and is driven by the processor datapath.
- Accepts one request at a time over a valid/ready handshake, range-checks the word address, and drives the memory strobes for a programmable number of cycles.
- Captures and extends the read data, then returns a registered one-cycle response to the datapath.

Parameters:
- WAIT_CYCLES, 1: cycles the memory strobe is held before read data is sampled; legal values >= 1, and 0 is treated as 1.
- MEM_DEPTH, 256: number of 32-bit words implemented; any address >= MEM_DEPTH is out of range.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept (high only in IDLE)
- req_write  input  1  1 = store, 0 = load
- req_byte  input  1  byte access (low 8 bits only)
- req_signed  input  1  sign-extend byte loads; ignored for word loads and stores
- req_addr  input  18  word address
- req_wdata  input  32  store data
- resp_valid  output  1  one-cycle completion pulse
- resp_data  output  32  load result (0 for stores and errors)
- resp_error  output  1  address out of range; qualified by resp_valid
- busy  output  1  high in ACCESS or DONE
- mem_address  output  18  to memory address
- mem_write_data  output  32  to memory write data
- mem_read  output  1  to memory read strobe
- mem_write  output  1  to memory write strobe
- mem_byte  output  1  to memory byte-operation select
- mem_read_data  input  32  from memory, combinational read data

Behaviour:
- Reset, synchronous on reset_n=0 at a clk edge:
  - state=IDLE, wait counter=0.
  - All outputs 0 except req_ready=1.
  - Captured request fields cleared.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1: register req_write/byte/signed/addr/wdata.
  - If addr < MEM_DEPTH, go to ACCESS with counter=1; otherwise go to DONE with the error flag set and no memory strobe asserted.
- ACCESS:
  - mem_address, mem_write_data and mem_byte are driven from the registers for every ACCESS cycle.
  - Loads: mem_read=1 for all WAIT_CYCLES cycles.
  - Stores: mem_write=1 only in the first ACCESS cycle, so the memory write is exactly one pulse.
  - The counter increments each cycle. On the edge where counter==WAIT_CYCLES:
    - Loads latch mem_read_data into resp_data. A word load is taken as-is. A byte load gives {24{bit7}, data[7:0]} if req_signed, else {24'b0, data[7:0]}.
    - Stores latch resp_data=0.
    - Go to DONE.
- DONE:
  - resp_valid=1 for exactly one cycle; resp_error reflects the range check.
  - Next state is IDLE. No backpressure: the response is not held.
- Outside ACCESS: mem_read=mem_write=0, mem_address=0, mem_write_data=0, mem_byte=0.
- resp_data and resp_error hold their values until the next DONE; consumers qualify them with resp_valid.
- Latency: request accepted at edge E. ACCESS occupies cycles E+1..E+W. resp_valid is high in cycle E+W+1. With W=1 a new request can be accepted at edge E+3.
- Out-of-range request: resp_valid is high in cycle E+1 with resp_error=1 and resp_data=0. No strobe is ever asserted.
- Request inputs change while busy: ignored; the registered copy is used.
- req_valid held high continuously: the next request is accepted on the first IDLE edge, and each is accepted exactly once.
- Reset asserted mid-ACCESS or in DONE: return to IDLE at that edge, strobes drop, and no resp_valid is produced for the dropped request. A store already pulsed is not undone.
- resp_valid is a registered output. The memory strobes and address are combinational decodes of the registered state and registered fields only, with no path from req_* to mem_*.

Test Plan:
- Word store then load, W=1:
  - Store addr=5, wdata=32'hDEADBEEF -> mem_write high exactly 1 cycle with mem_address=5; resp_valid at E+2 with resp_data=0, resp_error=0.
  - Load addr=5 -> mem_read high 1 cycle; resp_data=32'hDEADBEEF.
- Byte loads, memory word 32'h000000F0 at addr 7:
  - req_signed=1 -> resp_data=32'hFFFFFFF0.
  - req_signed=0 -> resp_data=32'h000000F0.
- W=3: load addr=2 (memory 32'h12345678) -> mem_read high cycles E+1..E+3, resp_valid only at E+4, resp_data=32'h12345678; req_ready=0 during E+1..E+4.
- Out of range: load addr=256 with MEM_DEPTH=256 -> no mem_read/mem_write ever asserted; resp_valid at E+1 with resp_error=1, resp_data=0.
- Back-to-back: req_valid held high with 3 loads presented in sequence -> each accepted once, resp_valid pulses spaced W+2 cycles apart, and changing req_addr during ACCESS does not alter mem_address.
- Reset mid-op: W=4 load, assert reset_n=0 at the edge after E+2 -> next cycle state IDLE, mem_read=0, req_ready=1, and no resp_valid observed afterwards.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the processor datapath and the data memory.
// Accepts one request at a time, range-checks the word address, holds the
// memory strobes for WAIT_CYCLES cycles and returns a registered response.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned MEM_DEPTH   = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    // Request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic        req_signed,
    input  logic [17:0] req_addr,
    input  logic [31:0] req_wdata,
    // Response side
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_error,
    output logic        busy,
    // Memory side
    output logic [17:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_byte,
    input  logic [31:0] mem_read_data
);

    // A wait of zero still needs one strobe cycle.
    localparam int unsigned WaitEff = (WAIT_CYCLES == 0) ? 1 : WAIT_CYCLES;
    localparam int unsigned CntW    = $clog2(WaitEff + 1);
    localparam logic [CntW-1:0] CntFirst = CntW'(1);
    localparam logic [CntW-1:0] CntLast  = CntW'(WaitEff);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e        r_state;
    state_e        w_state_next;

    logic [CntW-1:0] r_cnt;
    logic          r_write;
    logic          r_byte;
    logic          r_signed;
    logic [17:0]   r_addr;
    logic [31:0]   r_wdata;

    logic          r_resp_valid;
    logic [31:0]   r_resp_data;
    logic          r_resp_error;

    logic          w_accept;
    logic          w_in_range;
    logic          w_last;
    logic [31:0]   w_load_ext;

    assign w_accept   = (r_state == StIdle) && req_valid;
    assign w_in_range = (32'(req_addr) < MEM_DEPTH);
    assign w_last     = (r_state == StAccess) && (r_cnt == CntLast);

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_error = r_resp_error;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived outputs; memory side sees registered fields only.
    always_comb begin
        w_state_next   = r_state;
        req_ready      = 1'b0;
        busy           = 1'b0;
        mem_address    = 18'd0;
        mem_write_data = 32'd0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_byte       = 1'b0;
        unique case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = w_in_range ? StAccess : StDone;
                end
            end
            StAccess: begin
                busy           = 1'b1;
                mem_address    = r_addr;
                mem_write_data = r_wdata;
                mem_byte       = r_byte;
                mem_read       = !r_write;
                // Store strobe only in the first cycle so memory sees one write pulse.
                mem_write      = r_write && (r_cnt == CntFirst);
                if (r_cnt == CntLast) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                busy         = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Capture the request fields on acceptance; later req_* changes are ignored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_write  <= 1'b0;
            r_byte   <= 1'b0;
            r_signed <= 1'b0;
            r_addr   <= 18'd0;
            r_wdata  <= 32'd0;
        end else if (w_accept) begin
            r_write  <= req_write;
            r_byte   <= req_byte;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end
    end

    // Wait counter: starts at 1 on the first ACCESS cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_accept && w_in_range) begin
            r_cnt <= CntFirst;
        end else if (r_state == StAccess && !w_last) begin
            r_cnt <= r_cnt + CntFirst;
        end else begin
            r_cnt <= '0;
        end
    end

    // Byte loads take the low byte, zero- or sign-extended.
    always_comb begin
        w_load_ext = mem_read_data;
        if (r_byte) begin
            if (r_signed) begin
                w_load_ext = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
            end else begin
                w_load_ext = {24'd0, mem_read_data[7:0]};
            end
        end
    end

    // Response registers; data and error hold until the next completion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
            r_resp_error <= 1'b0;
        end else begin
            r_resp_valid <= (w_state_next == StDone);
            if (w_accept && !w_in_range) begin
                r_resp_data  <= 32'd0;
                r_resp_error <= 1'b1;
            end else if (w_last) begin
                r_resp_data  <= r_write ? 32'd0 : w_load_ext;
                r_resp_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: three instances with wait counts 1, 3 and 4
// share a clock, reset and a word memory model.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];

    // Instance W=1 signals
    logic        v1, rdy1, wr1, by1, sg1, rv1, re1, busy1, mr1, mw1, mb1;
    logic [17:0] a1, ma1;
    logic [31:0] wd1, rd1, mwd1, mrd1;
    // Instance W=3 signals
    logic        v3, rdy3, rv3, re3, busy3, mr3, mw3, mb3;
    logic [17:0] a3, ma3;
    logic [31:0] rd3, mwd3, mrd3;
    // Instance W=4 signals
    logic        v4, rdy4, rv4, re4, busy4, mr4, mw4, mb4;
    logic [17:0] a4, ma4;
    logic [31:0] rd4, mwd4, mrd4;

    logic        zero1 = 1'b0;
    logic [31:0] zero32 = 32'd0;

    assign mrd1 = mem[ma1[7:0]];
    assign mrd3 = mem[ma3[7:0]];
    assign mrd4 = mem[ma4[7:0]];

    mem_access_ctrl #(.WAIT_CYCLES(1), .MEM_DEPTH(256)) u_w1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(v1), .req_ready(rdy1), .req_write(wr1), .req_byte(by1),
        .req_signed(sg1), .req_addr(a1), .req_wdata(wd1),
        .resp_valid(rv1), .resp_data(rd1), .resp_error(re1), .busy(busy1),
        .mem_address(ma1), .mem_write_data(mwd1), .mem_read(mr1), .mem_write(mw1),
        .mem_byte(mb1), .mem_read_data(mrd1)
    );

    mem_access_ctrl #(.WAIT_CYCLES(3), .MEM_DEPTH(256)) u_w3 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(v3), .req_ready(rdy3), .req_write(zero1), .req_byte(zero1),
        .req_signed(zero1), .req_addr(a3), .req_wdata(zero32),
        .resp_valid(rv3), .resp_data(rd3), .resp_error(re3), .busy(busy3),
        .mem_address(ma3), .mem_write_data(mwd3), .mem_read(mr3), .mem_write(mw3),
        .mem_byte(mb3), .mem_read_data(mrd3)
    );

    mem_access_ctrl #(.WAIT_CYCLES(4), .MEM_DEPTH(256)) u_w4 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(v4), .req_ready(rdy4), .req_write(zero1), .req_byte(zero1),
        .req_signed(zero1), .req_addr(a4), .req_wdata(zero32),
        .resp_valid(rv4), .resp_data(rd4), .resp_error(re4), .busy(busy4),
        .mem_address(ma4), .mem_write_data(mwd4), .mem_read(mr4), .mem_write(mw4),
        .mem_byte(mb4), .mem_read_data(mrd4)
    );

    // Memory model written only by the W=1 instance.
    always @(posedge clk) begin
        if (mw1) begin
            if (mb1) mem[ma1[7:0]][7:0] <= mwd1[7:0];
            else     mem[ma1[7:0]]      <= mwd1;
        end
    end

    // Event counters: strobes and response pulses seen at clock edges.
    int strobes1 = 0;
    int resp1 = 0;
    int resp4 = 0;
    int strobes4 = 0;
    always @(posedge clk) begin
        if (mr1 || mw1) strobes1 <= strobes1 + 1;
        if (rv1)        resp1 <= resp1 + 1;
        if (rv4)        resp4 <= resp4 + 1;
        if (mr4 || mw4) strobes4 <= strobes4 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int s0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[7] = 32'h000000F0;
        mem[2] = 32'h12345678;
        v1 = 0; wr1 = 0; by1 = 0; sg1 = 0; a1 = '0; wd1 = '0;
        v3 = 0; a3 = '0;
        v4 = 0; a4 = '0;

        // Reset
        step(); step();
        chk("rst_ready1", 32'(rdy1), 32'd1);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_rv1", 32'(rv1), 32'd0);
        chk("rst_rdata1", rd1, 32'd0);
        chk("rst_strobe1", 32'({mr1, mw1, mb1}), 32'd0);
        chk("rst_ready4", 32'(rdy4), 32'd1);
        reset_n = 1'b1;
        step();

        // Word store addr 5
        v1 = 1; wr1 = 1; a1 = 18'd5; wd1 = 32'hDEADBEEF;
        step();
        v1 = 0; wr1 = 0;
        chk("st_mw", 32'(mw1), 32'd1);
        chk("st_addr", 32'(ma1), 32'd5);
        chk("st_wdata", mwd1, 32'hDEADBEEF);
        chk("st_ready", 32'(rdy1), 32'd0);
        chk("st_rv_early", 32'(rv1), 32'd0);
        step();
        chk("st_mw_off", 32'(mw1), 32'd0);
        chk("st_rv", 32'(rv1), 32'd1);
        chk("st_rdata", rd1, 32'd0);
        chk("st_err", 32'(re1), 32'd0);
        chk("st_mem", mem[5], 32'hDEADBEEF);
        step();
        chk("st_rv_off", 32'(rv1), 32'd0);
        chk("st_ready_back", 32'(rdy1), 32'd1);

        // Word load addr 5
        v1 = 1; a1 = 18'd5;
        step();
        v1 = 0;
        chk("ld_mr", 32'(mr1), 32'd1);
        chk("ld_addr", 32'(ma1), 32'd5);
        step();
        chk("ld_mr_off", 32'(mr1), 32'd0);
        chk("ld_rv", 32'(rv1), 32'd1);
        chk("ld_rdata", rd1, 32'hDEADBEEF);
        step();

        // Signed byte load addr 7
        v1 = 1; by1 = 1; sg1 = 1; a1 = 18'd7;
        step();
        v1 = 0;
        chk("lbs_byte", 32'(mb1), 32'd1);
        step();
        chk("lbs_rdata", rd1, 32'hFFFFFFF0);
        step();

        // Unsigned byte load addr 7
        v1 = 1; by1 = 1; sg1 = 0; a1 = 18'd7;
        step();
        v1 = 0; by1 = 0;
        step();
        chk("lbu_rdata", rd1, 32'h000000F0);
        step();

        // Out-of-range load addr 256
        s0 = strobes1;
        v1 = 1; a1 = 18'd256;
        step();
        v1 = 0;
        chk("oor_rv", 32'(rv1), 32'd1);
        chk("oor_err", 32'(re1), 32'd1);
        chk("oor_rdata", rd1, 32'd0);
        chk("oor_strobe_now", 32'({mr1, mw1}), 32'd0);
        step();
        chk("oor_rv_off", 32'(rv1), 32'd0);
        chk("oor_strobes", 32'(strobes1 - s0), 32'd0);

        // Back-to-back loads with req_valid held high
        s0 = resp1;
        v1 = 1; a1 = 18'd5;
        step();
        chk("b2b_a0", 32'(ma1), 32'd5);
        a1 = 18'd7;
        #1;
        chk("b2b_a0_hold", 32'(ma1), 32'd5);
        step();
        chk("b2b_rv0", 32'(rv1), 32'd1);
        chk("b2b_d0", rd1, 32'hDEADBEEF);
        step();
        chk("b2b_gap0", 32'(rv1), 32'd0);
        chk("b2b_ready0", 32'(rdy1), 32'd1);
        step();
        chk("b2b_a1", 32'(ma1), 32'd7);
        a1 = 18'd2;
        #1;
        chk("b2b_a1_hold", 32'(ma1), 32'd7);
        step();
        chk("b2b_rv1", 32'(rv1), 32'd1);
        chk("b2b_d1", rd1, 32'h000000F0);
        step();
        chk("b2b_gap1", 32'(rv1), 32'd0);
        step();
        chk("b2b_a2", 32'(ma1), 32'd2);
        v1 = 0;
        step();
        chk("b2b_rv2", 32'(rv1), 32'd1);
        chk("b2b_d2", rd1, 32'h12345678);
        step(); step(); step();
        chk("b2b_count", 32'(resp1 - s0), 32'd3);

        // W=3 load addr 2
        v3 = 1; a3 = 18'd2;
        step();
        v3 = 0;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("w3_mr_c%0d", c), 32'(mr3), 32'd1);
            chk($sformatf("w3_rdy_c%0d", c), 32'(rdy3), 32'd0);
            chk($sformatf("w3_rv_c%0d", c), 32'(rv3), 32'd0);
            step();
        end
        chk("w3_rv", 32'(rv3), 32'd1);
        chk("w3_rdata", rd3, 32'h12345678);
        chk("w3_mr_off", 32'(mr3), 32'd0);
        chk("w3_rdy_done", 32'(rdy3), 32'd0);
        step();
        chk("w3_rv_off", 32'(rv3), 32'd0);
        chk("w3_ready", 32'(rdy3), 32'd1);

        // W=4 load aborted by reset
        s0 = resp4;
        v4 = 1; a4 = 18'd2;
        step();
        v4 = 0;
        chk("w4_mr_c1", 32'(mr4), 32'd1);
        step();
        chk("w4_mr_c2", 32'(mr4), 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("w4_rst_mr", 32'(mr4), 32'd0);
        chk("w4_rst_ready", 32'(rdy4), 32'd1);
        chk("w4_rst_busy", 32'(busy4), 32'd0);
        for (int c = 0; c < 8; c++) step();
        chk("w4_no_resp", 32'(resp4 - s0), 32'd0);
        chk("w4_strobes", 32'(strobes4), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time bound so the run cannot hang.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
